// File: rtl/exp_golomb_decoder.sv
// Exp-Golomb ue(v)/se(v) decoder driving the upstream barrel shifter (prefix, then suffix).
// Optional te(v) range-1 support is enabled by defining EXP_GOLOMB_TE_EN.
module exp_golomb_decoder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] BitstreamShifted,
  input  logic        BarrelShifterReady,
  input  logic        Start,
  input  logic        Signed,
`ifdef EXP_GOLOMB_TE_EN
  input  logic        TeRange1,
`endif
  output logic        ShiftEn,
  output logic [4:0]  NumShift,
  output logic        Busy,
  output logic        Valid,
  output logic [15:0] Value,
  output logic        Error
);

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StPrefixShift = 3'd1;
  localparam logic [2:0] StWait        = 3'd2;
  localparam logic [2:0] StSuffixShift = 3'd3;
  localparam logic [2:0] StDone        = 3'd4;
  localparam logic [2:0] StErr         = 3'd5;

  logic [2:0]  state;
  logic [3:0]  lzReg;
  logic        signedReg;
  logic [15:0] suffixReg;
`ifdef EXP_GOLOMB_TE_EN
  logic        teReg;
  logic        teBit;
`endif

  logic [4:0]  lzComb;
  logic        found;
  logic [4:0]  suffixShamt;
  logic [15:0] suffixComb;
  logic [15:0] codeNum;
  logic [15:0] seValue;
  logic [15:0] decodedValue;

  always_comb begin
    lzComb = 5'd16;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && BitstreamShifted[15 - i]) begin
        lzComb = 5'(i);
        found  = 1'b1;
      end
    end
  end

  // Shift by 16 when LZ=0 yields an empty suffix.
  assign suffixShamt = 5'd16 - {1'b0, lzReg};
  assign suffixComb  = BitstreamShifted >> suffixShamt;

  assign codeNum = ((16'd1 << lzReg) - 16'd1) + suffixReg;
  assign seValue = codeNum[0] ? ((codeNum + 16'd1) >> 1) : (16'd0 - (codeNum >> 1));

  always_comb begin
    decodedValue = signedReg ? seValue : codeNum;
`ifdef EXP_GOLOMB_TE_EN
    if (teReg) decodedValue = {15'b0, ~teBit};
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      lzReg     <= 4'd0;
      signedReg <= 1'b0;
      suffixReg <= 16'd0;
`ifdef EXP_GOLOMB_TE_EN
      teReg     <= 1'b0;
      teBit     <= 1'b0;
`endif
      ShiftEn   <= 1'b0;
      NumShift  <= 5'd0;
      Busy      <= 1'b0;
      Valid     <= 1'b0;
      Value     <= 16'd0;
      Error     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (Start && BarrelShifterReady) begin
            signedReg <= Signed;
            Busy      <= 1'b1;
`ifdef EXP_GOLOMB_TE_EN
            teReg     <= TeRange1;
            if (TeRange1) begin
              teBit    <= BitstreamShifted[15];
              ShiftEn  <= 1'b1;
              NumShift <= 5'd1;
              state    <= StPrefixShift;
            end else
`endif
            if (lzComb == 5'd16) begin
              Error <= 1'b1;
              state <= StErr;
            end else begin
              lzReg    <= lzComb[3:0];
              ShiftEn  <= 1'b1;
              NumShift <= lzComb + 5'd1;
              state    <= StPrefixShift;
            end
          end
        end
        StPrefixShift: begin
          ShiftEn <= 1'b0;
`ifdef EXP_GOLOMB_TE_EN
          state   <= teReg ? StSuffixShift : StWait;
`else
          state   <= StWait;
`endif
        end
        StWait: begin
          suffixReg <= suffixComb;
          ShiftEn   <= (lzReg != 4'd0);
          NumShift  <= {1'b0, lzReg};
          state     <= StSuffixShift;
        end
        StSuffixShift: begin
          ShiftEn  <= 1'b0;
          NumShift <= 5'd0;
          Value    <= decodedValue;
          Valid    <= 1'b1;
          state    <= StDone;
        end
        StDone: begin
          Valid <= 1'b0;
          Busy  <= 1'b0;
          state <= StIdle;
        end
        StErr: begin
          Error <= 1'b0;
          Busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_golomb_decoder.sv
// Self-checking bench for exp_golomb_decoder with a behavioural barrel-shifter model.
// Exercises te(v) as well when EXP_GOLOMB_TE_EN is defined.
module tb_exp_golomb_decoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] BitstreamShifted;
  logic        BarrelShifterReady;
  logic        Start;
  logic        Signed;
`ifdef EXP_GOLOMB_TE_EN
  logic        TeRange1;
`endif
  logic        ShiftEn;
  logic [4:0]  NumShift;
  logic        Busy;
  logic        Valid;
  logic [15:0] Value;
  logic        Error;

  int testsRun = 0;
  int testsFailed = 0;

  logic [1023:0] streamBits = '1;
  int            pos = 0;
  int            basePos = 0;
  int            wrCursor = 0;
  int            cycleCnt = 0;
  logic [15:0]   expQ[$];
  logic [15:0]   obsQ[$];
  int            validCycles[$];
  int            spacingErr = 0;
  logic          prevShiftEn = 1'b0;
  logic [15:0]   lastExp = 16'd0;

  exp_golomb_decoder dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .BitstreamShifted   (BitstreamShifted),
    .BarrelShifterReady (BarrelShifterReady),
    .Start              (Start),
    .Signed             (Signed),
`ifdef EXP_GOLOMB_TE_EN
    .TeRange1           (TeRange1),
`endif
    .ShiftEn            (ShiftEn),
    .NumShift           (NumShift),
    .Busy               (Busy),
    .Valid              (Valid),
    .Value              (Value),
    .Error              (Error)
  );

  always #5 Clk = ~Clk;

  // Shifter model: a shift issued in cycle N is visible in the window in cycle N+1.
  always @(posedge Clk) begin
    cycleCnt <= cycleCnt + 1;
    if (ShiftEn) pos <= pos + int'(NumShift);
  end

  assign BitstreamShifted = streamBits[1023 - (pos - basePos) -: 16];

  always @(negedge Clk) begin
    if (Valid) begin
      obsQ.push_back(Value);
      validCycles.push_back(cycleCnt);
    end
    if (ShiftEn && prevShiftEn) spacingErr++;
    prevShiftEn = ShiftEn;
  end

  task automatic tick;
    @(negedge Clk);
    #1;
  endtask

  task automatic load_head(input logic [31:0] head);
    streamBits = '1;
    streamBits[1023 -: 32] = head;
    basePos = pos;
    wrCursor = 32;
  endtask

  task automatic new_stream;
    streamBits = '1;
    basePos = pos;
    wrCursor = 0;
  endtask

  task automatic append_code(input int unsigned codeNum);
    int unsigned v;
    int n;
    v = codeNum + 1;
    n = $clog2(v + 1);
    for (int i = 0; i < n - 1; i++) begin
      streamBits[1023 - wrCursor] = 1'b0;
      wrCursor++;
    end
    for (int i = n - 1; i >= 0; i--) begin
      streamBits[1023 - wrCursor] = v[i];
      wrCursor++;
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (obsQ.size() == 0 && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset;
    logic [23:0] got;
    Reset = 1'b1;
    Start = 1'b0;
    Signed = 1'b0;
    BarrelShifterReady = 1'b1;
`ifdef EXP_GOLOMB_TE_EN
    TeRange1 = 1'b0;
`endif
    load_head(32'hFFFF_FFFF);
    repeat (3) tick();
    got = {ShiftEn, NumShift, Busy, Valid, Value, Error};
    testsRun++;
    if (got !== 24'd0) begin
      testsFailed++;
      $display("FAIL reset_outputs: got %h want 000000", got);
    end
    Reset = 1'b0;
    tick();
    testsRun++;
    if ({ShiftEn, Busy, Valid, Error} !== 4'b0000) begin
      testsFailed++;
      $display("FAIL reset_idle: got %b want 0000", {ShiftEn, Busy, Valid, Error});
    end
  endtask

  task automatic test_timed_decodes;
    logic [31:0] heads[5];
    logic        sgns[5];
    logic [4:0]  ns1[5];
    logic [4:0]  ns2[5];
    logic [15:0] vals[5];
    heads = '{32'h8000_0000, 32'h2800_0000, 32'h2800_0000, 32'h0001_FFFF, 32'h0001_FFFF};
    sgns  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ns1   = '{5'd1, 5'd3, 5'd3, 5'd16, 5'd16};
    ns2   = '{5'd0, 5'd2, 5'd2, 5'd15, 5'd15};
    vals  = '{16'h0000, 16'h0004, 16'hFFFE, 16'h8001, 16'hFFFE};
    for (int c = 0; c < 5; c++) begin
      load_head(heads[c]);
      Signed = sgns[c];
      expQ.delete();
      obsQ.delete();
      expQ.push_back(vals[c]);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      testsRun++;
      if ({ShiftEn, NumShift, Busy} !== {1'b1, ns1[c], 1'b1}) begin
        testsFailed++;
        $display("FAIL timed_prefix case %0d: got %b want %b", c,
                 {ShiftEn, NumShift, Busy}, {1'b1, ns1[c], 1'b1});
      end
      tick();
      testsRun++;
      if ({ShiftEn, Busy} !== 2'b01) begin
        testsFailed++;
        $display("FAIL timed_wait case %0d: got %b want 01", c, {ShiftEn, Busy});
      end
      tick();
      testsRun++;
      if ({ShiftEn, NumShift} !== {ns2[c] != 5'd0, ns2[c]}) begin
        testsFailed++;
        $display("FAIL timed_suffix case %0d: got %b want %b", c,
                 {ShiftEn, NumShift}, {ns2[c] != 5'd0, ns2[c]});
      end
      tick();
      testsRun++;
      if ({Valid, Busy, Error} !== 3'b110) begin
        testsFailed++;
        $display("FAIL timed_valid case %0d: got %b want 110", c, {Valid, Busy, Error});
      end
      testsRun++;
      if (obsQ.size() == 0) begin
        testsFailed++;
        $display("FAIL timed_value case %0d: got no output want %h", c, expQ[0]);
      end else if (obsQ[0] !== expQ[0]) begin
        testsFailed++;
        $display("FAIL timed_value case %0d: got %h want %h", c, obsQ[0], expQ[0]);
      end
      lastExp = expQ.pop_front();
      obsQ.delete();
      tick();
      testsRun++;
      if ({Valid, Busy} !== 2'b00) begin
        testsFailed++;
        $display("FAIL timed_done case %0d: got %b want 00", c, {Valid, Busy});
      end
    end
  endtask

  task automatic test_reset_mid;
    load_head(32'h2800_0000);
    Signed = 1'b0;
    expQ.delete();
    obsQ.delete();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    testsRun++;
    if ({ShiftEn, NumShift, Busy, Valid, Value, Error} !== 24'd0) begin
      testsFailed++;
      $display("FAIL reset_mid: got %h want 000000", {ShiftEn, NumShift, Busy, Valid, Value, Error});
    end
    lastExp = 16'd0;
    tick();
    Reset = 1'b0;
    tick();
    load_head(32'h2800_0000);
    expQ.push_back(16'd4);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_valid(8);
    testsRun++;
    if (obsQ.size() == 0) begin
      testsFailed++;
      $display("FAIL reset_recover: got no output want 0004");
    end else if (obsQ[0] !== expQ[0]) begin
      testsFailed++;
      $display("FAIL reset_recover: got %h want %h", obsQ[0], expQ[0]);
    end
    lastExp = expQ.pop_front();
    obsQ.delete();
    tick();
  endtask

  task automatic test_error;
    load_head(32'h0000_0000);
    Signed = 1'b0;
    expQ.delete();
    obsQ.delete();
    Start = 1'b1;
    tick();
    testsRun++;
    if ({Error, ShiftEn, Busy, Valid} !== 4'b1010) begin
      testsFailed++;
      $display("FAIL error_pulse: got %b want 1010", {Error, ShiftEn, Busy, Valid});
    end
    testsRun++;
    if (Value !== lastExp) begin
      testsFailed++;
      $display("FAIL error_value_held: got %h want %h", Value, lastExp);
    end
    testsRun++;
    if (pos != basePos) begin
      testsFailed++;
      $display("FAIL error_no_shift: got %0d bits consumed want 0", pos - basePos);
    end
    // Start stays high through the error cycle; the next acceptance follows immediately.
    load_head(32'h8000_0000);
    expQ.push_back(16'd0);
    tick();
    testsRun++;
    if ({Error, Busy} !== 2'b00) begin
      testsFailed++;
      $display("FAIL error_clear: got %b want 00", {Error, Busy});
    end
    tick();
    Start = 1'b0;
    testsRun++;
    if ({ShiftEn, NumShift} !== {1'b1, 5'd1}) begin
      testsFailed++;
      $display("FAIL error_reaccept: got %b want 100001", {ShiftEn, NumShift});
    end
    wait_valid(8);
    testsRun++;
    if (obsQ.size() == 0) begin
      testsFailed++;
      $display("FAIL error_next_value: got no output want 0000");
    end else if (obsQ[0] !== expQ[0]) begin
      testsFailed++;
      $display("FAIL error_next_value: got %h want %h", obsQ[0], expQ[0]);
    end
    lastExp = expQ.pop_front();
    obsQ.delete();
    tick();
  endtask

  task automatic test_not_ready;
    int bad;
    bad = 0;
    load_head(32'h2800_0000);
    BarrelShifterReady = 1'b0;
    Start = 1'b1;
    repeat (6) begin
      tick();
      if (Busy || ShiftEn || Valid || Error) bad++;
    end
    Start = 1'b0;
    BarrelShifterReady = 1'b1;
    testsRun++;
    if (bad != 0 || pos != basePos) begin
      testsFailed++;
      $display("FAIL not_ready: got %0d active cycles, %0d bits consumed want 0 and 0",
               bad, pos - basePos);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int unsigned k;
    int budget;
    new_stream();
    expQ.delete();
    obsQ.delete();
    validCycles.delete();
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 300);
      append_code(k);
      expQ.push_back(k[15:0]);
    end
    Signed = 1'b0;
    Start = 1'b1;
    budget = 0;
    while (obsQ.size() < 8 && budget < 100) begin
      tick();
      budget++;
    end
    Start = 1'b0;
    testsRun++;
    if (obsQ.size() < 8) begin
      testsFailed++;
      $display("FAIL b2b_timeout: got %0d outputs want 8", obsQ.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        testsRun++;
        if (obsQ[i] !== expQ[i]) begin
          testsFailed++;
          $display("FAIL b2b_value %0d: got %h want %h", i, obsQ[i], expQ[i]);
        end
      end
      for (int i = 1; i < 8; i++) begin
        testsRun++;
        if (validCycles[i] - validCycles[i - 1] != 5) begin
          testsFailed++;
          $display("FAIL b2b_spacing %0d: got %0d cycles want 5", i,
                   validCycles[i] - validCycles[i - 1]);
        end
      end
      lastExp = expQ[7];
    end
    expQ.delete();
    obsQ.delete();
    tick();
    tick();
  endtask

  task automatic test_se_random;
    int s;
    int unsigned cn;
    new_stream();
    expQ.delete();
    obsQ.delete();
    for (int i = 0; i < 10; i++) begin
      s = int'($urandom_range(0, 600)) - 300;
      cn = (s > 0) ? int'(2 * s - 1) : int'(-2 * s);
      append_code(cn);
      expQ.push_back(16'(s));
    end
    Signed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_valid(8);
      testsRun++;
      if (obsQ.size() == 0) begin
        testsFailed++;
        $display("FAIL se_random %0d: got no output want %h", i, expQ[0]);
      end else if (obsQ[0] !== expQ[0]) begin
        testsFailed++;
        $display("FAIL se_random %0d: got %h want %h", i, obsQ[0], expQ[0]);
      end
      lastExp = expQ.pop_front();
      obsQ.delete();
      tick();
    end
    Signed = 1'b0;
  endtask

`ifdef EXP_GOLOMB_TE_EN
  task automatic test_te;
    load_head(32'h0000_0000);
    expQ.delete();
    obsQ.delete();
    expQ.push_back(16'd1);
    TeRange1 = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    TeRange1 = 1'b0;
    testsRun++;
    if ({ShiftEn, NumShift, Error} !== {1'b1, 5'd1, 1'b0}) begin
      testsFailed++;
      $display("FAIL te_shift: got %b want 1000010", {ShiftEn, NumShift, Error});
    end
    tick();
    testsRun++;
    if ({ShiftEn, Valid, Error} !== 3'b000) begin
      testsFailed++;
      $display("FAIL te_cycle2: got %b want 000", {ShiftEn, Valid, Error});
    end
    tick();
    testsRun++;
    if ({Valid, Error} !== 2'b10 || obsQ.size() == 0) begin
      testsFailed++;
      $display("FAIL te_valid: got %b want 10", {Valid, Error});
    end else if (obsQ[0] !== expQ[0]) begin
      testsFailed++;
      $display("FAIL te_value: got %h want %h", obsQ[0], expQ[0]);
    end
    expQ.delete();
    obsQ.delete();
    tick();
  endtask
`endif

  task automatic test_shift_spacing;
    testsRun++;
    if (spacingErr != 0) begin
      testsFailed++;
      $display("FAIL shift_spacing: got %0d back-to-back ShiftEn cycles want 0", spacingErr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_timed_decodes();
    test_reset_mid();
    test_error();
    test_not_ready();
    test_back_to_back();
    test_se_random();
`ifdef EXP_GOLOMB_TE_EN
    test_te();
`endif
    test_shift_spacing();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/exp_golomb_decoder.md
# exp_golomb_decoder

Decodes one Exp-Golomb codeword (ue(v) or se(v)) from the head of the bitstream window presented by the barrel shifter. It drives the shifter's ShiftEn/NumShift to consume the prefix and then the suffix, and returns the decoded value with a one-cycle Valid pulse. It sits directly downstream of the barrel shifter and is shared by the CAVLC slice and macroblock header parsers.

## Interface
- No parameters; widths are fixed by the 16-bit shifter window.
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state and outputs
- BitstreamShifted  in  16  shifter window; bit 15 is the next unread bit
- BarrelShifterReady  in  1  window holds valid data
- Start  in  1  request one decode; accepted only in IDLE while BarrelShifterReady=1
- Signed  in  1  sampled with Start; 0 selects ue(v), 1 selects se(v)
- ShiftEn  out  1  registered; shifter consumes NumShift bits at end of this cycle
- NumShift  out  5  registered; bits to consume, 0..16
- Busy  out  1  high from the cycle after acceptance until the Valid/Error cycle, inclusive
- Valid  out  1  one-cycle pulse; Value is valid
- Value  out  16  codeNum for ue(v); two's-complement result for se(v); held until the next Valid
- Error  out  1  one-cycle pulse; the window was all zeros (prefix too long)

## Operation
- Reset values: state IDLE; ShiftEn=0, NumShift=0, Busy=0, Valid=0, Value=0, Error=0.
- States: IDLE, PREFIX_SHIFT, WAIT, SUFFIX_SHIFT, DONE, ERR.
- **IDLE:**
  - When Start=1 and BarrelShifterReady=1, compute LZ, the leading-zero count of BitstreamShifted (0..16).
  - If LZ<16: register LZ and Signed; set ShiftEn<=1 and NumShift<=LZ+1; go to PREFIX_SHIFT.
  - If LZ=16: go to ERR. No shift is issued.
  - Start while BarrelShifterReady=0 is ignored; the block stays in IDLE.
- **PREFIX_SHIFT:** ShiftEn is high for this cycle. Set ShiftEn<=0; go to WAIT.
- **WAIT:**
  - The window now starts at the suffix. Capture Suffix = BitstreamShifted[15:16-LZ]; Suffix=0 when LZ=0.
  - Set ShiftEn<=(LZ!=0) and NumShift<=LZ; go to SUFFIX_SHIFT.
- **SUFFIX_SHIFT:**
  - Set ShiftEn<=0 and NumShift<=0.
  - Compute codeNum = (2^LZ − 1) + Suffix, 16 bits unsigned. The maximum is 65534, so it never overflows.
  - ue(v): Value<=codeNum.
  - se(v): odd codeNum gives Value<=(codeNum+1)>>1; even codeNum gives Value<=−(codeNum>>1), 16-bit two's complement.
  - Set Valid<=1 and go to DONE.
- **DONE:** Valid is high for this cycle. Clear Valid; return to IDLE.
- **ERR:** Error is high for this cycle. Clear Error; return to IDLE. Value is unchanged.
- ShiftEn is never high in two consecutive cycles. This gives the shifter one full cycle to update its window.
- Start is ignored outside IDLE, including in the DONE and ERR cycles.
- Reset asserted mid-decode immediately returns everything to reset values. A partial shift already issued is not undone; upstream must flush the bitstream.

## Timing
- Start accepted at cycle 0.
- ShiftEn (prefix) high in cycle 1.
- Suffix captured in cycle 2.
- ShiftEn (suffix) high in cycle 3, only if LZ≠0.
- Valid in cycle 4.
- Error case: Error high in cycle 1, no ShiftEn; next Start can be accepted in cycle 2.
- Busy is high in cycles 1..4 (1..1 for the error case).
- The earliest next acceptance is the cycle after Valid, giving a throughput of one codeword per 5 cycles.
- The shifter window is required to reflect a shift in the cycle after the ShiftEn cycle.

## Configuration
- Macro: EXP_GOLOMB_TE_EN.
- **Defined:**
  - Adds input port TeRange1 (1 bit), sampled with Start.
  - When TeRange1=1, the codeword is te(v) with range 1. In IDLE the block captures bit 15 and sets ShiftEn<=1, NumShift<=1.
  - PREFIX_SHIFT then goes directly to SUFFIX_SHIFT, which sets Value<={15'b0, ~bit15} and Valid<=1. Valid arrives in cycle 3.
  - The all-zero window check does not apply to te(v).
  - When TeRange1=0, behaviour is the plain ue/se path.
- **Undefined:** TeRange1 is absent; only ue(v)/se(v) are decoded.

## Test plan
- ue, window 0x8000 -> NumShift=1 in cycle 1, no suffix shift, Valid in cycle 4 with Value=0.
- ue, window 0x2800, then 0x4000 after the 3-bit shift -> NumShift=3 then NumShift=2, Value=4. The same stimulus with Signed=1 gives Value=0xFFFE (−2).
- se, window 0x0001, then 0xFFFF after the 16-bit shift -> NumShift=16 then 15, codeNum=65534, Value=0x8001 (−32767).
- Window 0x0000 -> no ShiftEn, Error pulse in cycle 1, Valid stays low, Busy high for 1 cycle.
- Start held high continuously -> decodes accepted every 5 cycles. Start with BarrelShifterReady=0 -> no response.
- Reset asserted in cycle 2 of a decode -> all outputs 0 immediately. A fresh Start after reset decodes correctly.
- (EXP_GOLOMB_TE_EN) TeRange1=1, window 0x0000 -> NumShift=1 in cycle 1, Valid in cycle 3, Value=1, no Error.
